// File: rtl/mil_mem_mux_encoder_pkg.sv
// Purpose: shared types and escape-word field layout for the MIL-to-memory mux encoder.
// Contents: WordType codes, encoder FSM states, escape field positions, escape tail builder.
// Escape word layout: [WORD_W-1:6] prefix, [5:2] channel, [1:0] word type.
package mil_mem_mux_encoder_pkg;

    // MIL-STD-1553 decoded word type; the same codes go into the escape type field.
    typedef enum logic [1:0] {
        WERROR   = 2'd0,
        WCOMMAND = 2'd1,
        WSTATUS  = 2'd2,
        WDATA    = 2'd3
    } word_type_t;

    typedef enum logic [2:0] {
        IDLE,
        ESC_LOAD,
        ESC_WAIT,
        DATA_LOAD,
        DATA_WAIT,
        REPORT
    } state_t;

    localparam int ESC_TYPE_LSB   = 0;
    localparam int ESC_CH_LSB     = 2;
    localparam int ESC_PREFIX_LSB = 6;

    // Low six bits of an escape word: channel and type fields.
    function automatic logic [ESC_PREFIX_LSB-1:0] esc_tail(input logic [3:0] ch,
                                                           input word_type_t t);
        esc_tail = '0;
        esc_tail[ESC_CH_LSB +: 4]   = ch;
        esc_tail[ESC_TYPE_LSB +: 2] = t;
    endfunction

endpackage

// File: rtl/mil_mem_mux_encoder_arb.sv
// Purpose: round-robin grant over CHANNELS requesters, searching from an internal pointer.
// Ports: clk/rst, req vector in, update strobe in (moves pointer past grant_ch), grant_vld/grant_ch out.
// Latency: grant is combinational; pointer moves on the edge where update is high.
module mil_rr_arbiter
    import mil_mem_mux_encoder_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                update,
    output logic                grant_vld,
    output logic [3:0]          grant_ch
);

    logic [3:0] ptr;
    int         idx;

    // First requester at or after ptr, wrapping. Inner loop keeps every index constant.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (!grant_vld && c == idx && req[c]) begin
                    grant_vld = 1'b1;
                    grant_ch  = 4'(c);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (update) begin
            ptr <= (int'(grant_ch) + 1 >= CHANNELS) ? 4'd0 : grant_ch + 4'd1;
        end
    end

endmodule

// File: rtl/mil_mem_mux_encoder.sv
// Purpose: round-robin mux of CHANNELS MIL word streams onto one memory push stream, inserting
//          an escape word {prefix, channel, type} whenever the bare data word would be ambiguous.
// Ports: mil_request/mil_data_word/mil_data_type in, mil_done out; push_data/push_request out,
//        push_done in; timeout_err out. Optional watchdog: define MILENC_TIMEOUT_EN.
module mil_mem_mux_encoder
    import mil_mem_mux_encoder_pkg::*;
#(
    parameter int                 CHANNELS       = 4,
    parameter int                 WORD_W         = 16,
    parameter logic [WORD_W-7:0]  ESC_PREFIX     = 10'h3FE,
    parameter int                 TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        mil_request,
    input  logic [CHANNELS*WORD_W-1:0] mil_data_word,
    input  logic [CHANNELS*2-1:0]      mil_data_type,
    output logic [CHANNELS-1:0]        mil_done,
    output logic [WORD_W-1:0]          push_data,
    output logic                       push_request,
    input  logic                       push_done,
    output logic                       timeout_err
);

    state_t              state;
    logic [WORD_W-1:0]   g_word;
    word_type_t          g_type;
    logic [3:0]          g_ch;
    logic [3:0]          last_ch;
    logic                last_valid;
    logic                aborted;

    logic                grant_vld;
    logic [3:0]          grant_ch;
    logic [WORD_W-1:0]   sel_word;
    word_type_t          sel_type;
    logic                need_esc;
    logic [CHANNELS-1:0] g_onehot;
    logic                expired;

    mil_rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (mil_request),
        .update    (state == IDLE && grant_vld),
        .grant_vld (grant_vld),
        .grant_ch  (grant_ch)
    );

    // Granted channel's payload. need_esc is evaluated on exactly the values latched at grant,
    // so the first push_request can already be registered on the grant edge.
    always_comb begin
        sel_word = '0;
        sel_type = WERROR;
        g_onehot = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(grant_ch) == c) begin
                sel_word = mil_data_word[c*WORD_W +: WORD_W];
                sel_type = word_type_t'(mil_data_type[c*2 +: 2]);
            end
            g_onehot[c] = (int'(g_ch) == c);
        end
        need_esc = (sel_type != WDATA)
                || (sel_word[WORD_W-1:ESC_PREFIX_LSB] == ESC_PREFIX)
                || !last_valid
                || (grant_ch != last_ch);
    end

`ifdef MILENC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts WAIT cycles; anything other than a WAIT state (including LOAD) clears it.
    always_ff @(posedge clk) begin
        if (rst || !(state == ESC_WAIT || state == DATA_WAIT)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            push_request <= 1'b0;
            push_data    <= '0;
            mil_done     <= '0;
            timeout_err  <= 1'b0;
            g_word       <= '0;
            g_type       <= WERROR;
            g_ch         <= '0;
            last_ch      <= '0;
            last_valid   <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            push_request <= 1'b0;
            mil_done     <= '0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        g_word       <= sel_word;
                        g_type       <= sel_type;
                        g_ch         <= grant_ch;
                        aborted      <= 1'b0;
                        push_request <= 1'b1;
                        if (need_esc) begin
                            state     <= ESC_LOAD;
                            push_data <= {ESC_PREFIX, esc_tail(grant_ch, sel_type)};
                        end else begin
                            state     <= DATA_LOAD;
                            push_data <= sel_word;
                        end
                    end
                end
                ESC_LOAD:  state <= ESC_WAIT;
                ESC_WAIT: begin
                    if (push_done) begin
                        state        <= DATA_LOAD;
                        push_request <= 1'b1;
                        push_data    <= g_word;
                    end else if (expired) begin
                        // Abort skips the data word but still releases the source.
                        state       <= REPORT;
                        push_data   <= '0;
                        mil_done    <= g_onehot;
                        timeout_err <= 1'b1;
                        aborted     <= 1'b1;
                    end
                end
                DATA_LOAD: state <= DATA_WAIT;
                DATA_WAIT: begin
                    if (push_done || expired) begin
                        state       <= REPORT;
                        push_data   <= '0;
                        mil_done    <= g_onehot;
                        timeout_err <= !push_done;
                        aborted     <= !push_done;
                    end
                end
                REPORT: begin
                    state      <= IDLE;
                    last_ch    <= g_ch;
                    // After an abort the reader may have lost sync, so force an escape next.
                    last_valid <= !aborted;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mil_mem_mux_encoder.sv
module tb_mil_mem_mux_encoder;

    localparam int CH = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   mil_request = '0;
    logic [CH*W-1:0] mil_data_word = '0;
    logic [CH*2-1:0] mil_data_type = '0;
    logic [CH-1:0]   mil_done;
    logic [W-1:0]    push_data;
    logic            push_request;
    logic            push_done = 1'b1;
    logic            timeout_err;

    int checks = 0;
    int errors = 0;
    int to_seen = 0;
    logic [W-1:0] exp_push[$];
    int           exp_done[$];

    mil_mem_mux_encoder #(
        .CHANNELS(CH), .WORD_W(W), .ESC_PREFIX(10'h3FE), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mil_request   (mil_request),
        .mil_data_word (mil_data_word),
        .mil_data_type (mil_data_type),
        .mil_done      (mil_done),
        .push_data     (push_data),
        .push_request  (push_request),
        .push_done     (push_done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Scoreboard monitor: every push strobe and every mil_done pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (push_request) begin
                if (exp_push.size() == 0) begin
                    chk("push_unexpected", push_data, 0);
                    if (push_data == 0) begin
                        errors++;
                        $display("FAIL push_unexpected got strobe want none");
                    end
                end else begin
                    chk("push_data", push_data, exp_push.pop_front());
                end
            end
            if (mil_done != '0) begin
                logic [CH-1:0] want;
                want = '0;
                if (exp_done.size() != 0) begin
                    want[exp_done.pop_front()] = 1'b1;
                end
                chk("mil_done", mil_done, want);
            end
            if (timeout_err) begin
                to_seen++;
            end
        end
    end

    task automatic gap();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic [1:0] t, input logic [W-1:0] w);
        mil_data_word[c*W +: W] = w;
        mil_data_type[c*2 +: 2] = t;
    endtask

    // Raise requests in mask; each channel drops its request on seeing its mil_done.
    task automatic issue(input logic [CH-1:0] mask, input int budget, output int cyc, output bit ok);
        mil_request = mask;
        cyc = 0;
        while (mil_request != '0 && cyc < budget) begin
            gap();
            cyc++;
            for (int c = 0; c < CH; c++) begin
                if (mil_done[c]) mil_request[c] = 1'b0;
            end
        end
        ok = (mil_request == '0);
        mil_request = '0;
    endtask

    task automatic run(input string name, input logic [CH-1:0] mask, input int want_cyc);
        int cyc;
        bit ok;
        issue(mask, 200, cyc, ok);
        chk({name, "_done"}, ok, 1);
        if (want_cyc >= 0) chk({name, "_cycles"}, cyc, want_cyc);
        gap();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_push_request", push_request, 0);
        chk("rst_mil_done", mil_done, 0);
        chk("rst_push_data", push_data, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;

        // First word after reset is escaped; type WDATA=3 lands in the low bits.
        set_ch(0, 2'd3, 16'h1234);
        exp_push.push_back(16'hFF83); exp_push.push_back(16'h1234); exp_done.push_back(0);
        run("t1_first", 4'b0001, 5);

        set_ch(0, 2'd3, 16'h5678);
        exp_push.push_back(16'h5678); exp_done.push_back(0);
        run("t2_bare", 4'b0001, 3);

        set_ch(2, 2'd1, 16'h0841);
        exp_push.push_back(16'hFF89); exp_push.push_back(16'h0841); exp_done.push_back(2);
        run("t3_cmd", 4'b0100, 5);

        set_ch(1, 2'd3, 16'h1111);
        exp_push.push_back(16'hFF87); exp_push.push_back(16'h1111); exp_done.push_back(1);
        run("t4_ch1", 4'b0010, 5);

        set_ch(1, 2'd3, 16'hFF93);
        exp_push.push_back(16'hFF87); exp_push.push_back(16'hFF93); exp_done.push_back(1);
        run("t4_collide", 4'b0010, 5);

        // Pointer is 2 now; servicing ch3 wraps it back to 0.
        set_ch(3, 2'd2, 16'h0003);
        exp_push.push_back(16'hFF8E); exp_push.push_back(16'h0003); exp_done.push_back(3);
        run("t5_status", 4'b1000, 5);

        for (int c = 0; c < CH; c++) begin
            set_ch(c, 2'd3, 16'hA000 + 16'(c));
            exp_push.push_back(16'hFF83 + 16'(4 * c));
            exp_push.push_back(16'hA000 + 16'(c));
            exp_done.push_back(c);
        end
        run("t6_all", 4'b1111, 23);

        push_done = 1'b0;
        set_ch(0, 2'd3, 16'h2222);
        exp_push.push_back(16'hFF83); exp_done.push_back(0);
`ifdef MILENC_TIMEOUT_EN
        run("t7_timeout", 4'b0001, 10);
        chk("t7_timeout_err", to_seen, 1);
        push_done = 1'b1;
        set_ch(0, 2'd3, 16'h2223);
        exp_push.push_back(16'hFF83); exp_push.push_back(16'h2223); exp_done.push_back(0);
        run("t8_after_abort", 4'b0001, 5);
`else
        exp_push.push_back(16'h2222);
        mil_request = 4'b0001;
        repeat (40) gap();
        chk("t7_stall_hold", push_data, 16'hFF83);
        chk("t7_stall_no_done", exp_done.size(), 1);
        chk("t7_stall_pending", exp_push.size(), 1);
        push_done = 1'b1;
        run("t7_release", 4'b0001, -1);
        set_ch(0, 2'd3, 16'h2223);
        exp_push.push_back(16'h2223); exp_done.push_back(0);
        run("t8_bare", 4'b0001, 3);
`endif

        // Reset while parked in DATA_WAIT: no mil_done, and the next word is re-escaped.
        push_done = 1'b0;
        set_ch(0, 2'd3, 16'h3333);
        exp_push.push_back(16'h3333);
        mil_request = 4'b0001;
        gap();
        gap();
        chk("t9_in_wait", push_data, 16'h3333);
        mil_request = '0;
        rst = 1'b1;
        gap();
        chk("t9_rst_push_request", push_request, 0);
        chk("t9_rst_mil_done", mil_done, 0);
        chk("t9_rst_push_data", push_data, 0);
        rst = 1'b0;
        push_done = 1'b1;
        set_ch(0, 2'd3, 16'h4444);
        exp_push.push_back(16'hFF83); exp_push.push_back(16'h4444); exp_done.push_back(0);
        run("t9_reescape", 4'b0001, 5);

        repeat (3) gap();
        chk("end_push_queue", exp_push.size(), 0);
        chk("end_done_queue", exp_done.size(), 0);
`ifdef MILENC_TIMEOUT_EN
        chk("end_timeouts", to_seen, 1);
`else
        chk("end_timeouts", to_seen, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got stuck want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
